decode_writeback: RTL and testbench

Y86-64 SEQ decode and write-back stage: turns the fetch stage's `icode`/`ifun`/`rA`/`rB` into register source and destination IDs and reads `valA`/`valB` combinationally. It holds the 15×64-bit program register file and commits `valE`/`valM` at the end of the instruction cycle. It sits directly downstream of fetch, feeds execute, and receives `valE` from execute and `valM` from memory for write-back.

---
 rtl/y86_pkg.sv | 35 +++
 rtl/regfile_15x64.sv | 42 ++++
 rtl/decode_writeback.sv | 101 ++++++++++
 tb/tb_decode_writeback.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs and word types.
// The fetch, execute, memory and decode/write-back stages all import this package.
package y86_pkg;

  typedef logic [3:0]  reg_id_t;
  typedef logic [63:0] word_t;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam reg_id_t RNONE = 4'hF;
  localparam reg_id_t RSP   = 4'h4;

  typedef struct packed {
    reg_id_t src_a;
    reg_id_t src_b;
    reg_id_t dst_e;
    reg_id_t dst_m;
  } dec_ids_t;

  function automatic logic is_rnone(input reg_id_t id);
    return id == RNONE;
  endfunction

endpackage

// File: rtl/regfile_15x64.sv
// Program register file: async-reset storage, two read ports plus a debug port
// (ID F reads 0), two write ports where the M port overrides the E port.
module regfile_15x64
  import y86_pkg::*;
#(
  parameter int NREG = 15
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    we,
  input  reg_id_t src_a,
  input  reg_id_t src_b,
  input  reg_id_t dbg_idx,
  input  reg_id_t dst_e,
  input  word_t   val_e,
  input  reg_id_t dst_m,
  input  word_t   val_m,
  output word_t   rd_a,
  output word_t   rd_b,
  output word_t   dbg_val
);

  localparam reg_id_t NREG_ID = reg_id_t'(NREG);

  word_t regs [NREG];

  // IDs at or above NREG (including RNONE) have no storage behind them.
  assign rd_a    = (src_a   < NREG_ID) ? regs[src_a]   : '0;
  assign rd_b    = (src_b   < NREG_ID) ? regs[src_b]   : '0;
  assign dbg_val = (dbg_idx < NREG_ID) ? regs[dbg_idx] : '0;

  // The M write is issued last so it wins when both ports target one register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      if (dst_e < NREG_ID) regs[dst_e] <= val_e;
      if (dst_m < NREG_ID) regs[dst_m] <= val_m;
    end
  end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode / write-back: combinational register-ID decode and reads,
// commit of valE/valM into the program register file on the rising edge.
module decode_writeback
  import y86_pkg::*;
#(
  parameter int      NREG   = 15,
  parameter reg_id_t RSP_ID = RSP
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    [3:0] icode,
  input  logic    [3:0] ifun,
  input  reg_id_t rA,
  input  reg_id_t rB,
  input  logic    cnd,
  input  word_t   valE,
  input  word_t   valM,
  input  logic    wb_en,
  input  reg_id_t dbg_idx,
  output reg_id_t srcA,
  output reg_id_t srcB,
  output reg_id_t dstE,
  output reg_id_t dstM,
  output word_t   valA,
  output word_t   valB,
  output word_t   dbg_val
);

  dec_ids_t ids;

  // ifun only selects the ALU op / condition downstream; decode ignores it.
  logic unused_ifun;
  assign unused_ifun = ^ifun;

  always_comb begin
    ids = '{src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE};
    case (icode)
      I_RRMOVQ: begin
        ids.src_a = rA;
        ids.dst_e = cnd ? rB : RNONE;
      end
      I_IRMOVQ: ids.dst_e = rB;
      I_RMMOVQ: begin
        ids.src_a = rA;
        ids.src_b = rB;
      end
      I_MRMOVQ: begin
        ids.src_b = rB;
        ids.dst_m = rA;
      end
      I_OPQ: begin
        ids.src_a = rA;
        ids.src_b = rB;
        ids.dst_e = rB;
      end
      I_CALL: begin
        ids.src_b = RSP_ID;
        ids.dst_e = RSP_ID;
      end
      I_RET: begin
        ids.src_a = RSP_ID;
        ids.src_b = RSP_ID;
        ids.dst_e = RSP_ID;
      end
      I_PUSHQ: begin
        ids.src_a = rA;
        ids.src_b = RSP_ID;
        ids.dst_e = RSP_ID;
      end
      I_POPQ: begin
        ids.src_a = RSP_ID;
        ids.src_b = RSP_ID;
        ids.dst_e = RSP_ID;
        ids.dst_m = rA;
      end
      default: ;
    endcase
  end

  assign srcA = ids.src_a;
  assign srcB = ids.src_b;
  assign dstE = ids.dst_e;
  assign dstM = ids.dst_m;

  regfile_15x64 #(.NREG(NREG)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_en),
    .src_a   (ids.src_a),
    .src_b   (ids.src_b),
    .dbg_idx (dbg_idx),
    .dst_e   (ids.dst_e),
    .val_e   (valE),
    .dst_m   (ids.dst_m),
    .val_m   (valM),
    .rd_a    (valA),
    .rd_b    (valB),
    .dbg_val (dbg_val)
  );

endmodule

// File: tb/tb_decode_writeback.sv
// Directed bench for decode_writeback: expectations queued at drive time,
// popped and compared with immediate assertions when the DUT output is sampled.
module tb_decode_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  icode, ifun, rA, rB, dbg_idx;
  logic        cnd, wb_en;
  logic [63:0] valE, valM;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [63:0] valA, valB, dbg_val;

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] exp_q [$];
  string       tag_q [$];

  decode_writeback dut (
    .clk(clk), .rst_n(rst_n), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .cnd(cnd), .valE(valE), .valM(valM), .wb_en(wb_en), .dbg_idx(dbg_idx),
    .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
    .valA(valA), .valB(valB), .dbg_val(dbg_val)
  );

  always #5 clk = ~clk;

  task automatic expect_v(input string tag, input logic [63:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic chk(input logic [63:0] obs);
    logic [63:0] e;
    string t;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: got %h expected nothing queued", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: got %h expected %h", t, obs, e);
      end
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [63:0] e, input logic [63:0] m,
                       input logic en);
    icode = ic; rA = a; rB = b; cnd = c; valE = e; valM = m; wb_en = en;
    #1;
  endtask

  // One commit edge, then settle on the falling edge with writes disabled.
  task automatic commit();
    @(posedge clk);
    @(negedge clk);
    wb_en = 1'b0;
    #1;
  endtask

  task automatic read_dbg(input logic [3:0] idx);
    dbg_idx = idx;
    #1;
    chk(dbg_val);
  endtask

  initial begin
    rst_n = 1'b0; icode = 4'h1; ifun = 4'h0; rA = 4'hF; rB = 4'hF;
    cnd = 1'b0; valE = '0; valM = '0; wb_en = 1'b0; dbg_idx = 4'h0;
    #12;

    // Reset state
    for (int i = 0; i < 16; i++) begin
      expect_v($sformatf("reset_r%0d", i), 64'h0);
      read_dbg(4'(i));
    end
    drive(4'h6, 4'h0, 4'h1, 1'b0, 64'h0, 64'h0, 1'b0);
    expect_v("reset_valA", 64'h0); chk(valA);
    expect_v("reset_valB", 64'h0); chk(valB);
    @(negedge clk);
    rst_n = 1'b1;

    // irmovq $0x2A, %rbx
    drive(4'h3, 4'hF, 4'h3, 1'b0, 64'h2A, 64'h0, 1'b1);
    expect_v("irmovq_dstE", 64'h3); chk(64'(dstE));
    expect_v("irmovq_dstM", 64'hF); chk(64'(dstM));
    expect_v("irmovq_srcA", 64'hF); chk(64'(srcA));
    commit();
    expect_v("irmovq_r3", 64'h2A); read_dbg(4'h3);

    // popq %rsp: M write beats E write
    drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'h55, 1'b1);
    expect_v("popq_srcA", 64'h4); chk(64'(srcA));
    expect_v("popq_srcB", 64'h4); chk(64'(srcB));
    expect_v("popq_dstE", 64'h4); chk(64'(dstE));
    expect_v("popq_dstM", 64'h4); chk(64'(dstM));
    commit();
    expect_v("popq_r4", 64'h55); read_dbg(4'h4);
    expect_v("popq_valA", 64'h55); chk(valA);

    // cmovXX, preload R2 = 0x33
    drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h33, 64'h0, 1'b1);
    commit();
    drive(4'h2, 4'h1, 4'h2, 1'b0, 64'h77, 64'h0, 1'b1);
    expect_v("cmov_nc_dstE", 64'hF); chk(64'(dstE));
    expect_v("cmov_srcA", 64'h1); chk(64'(srcA));
    commit();
    expect_v("cmov_nc_r2", 64'h33); read_dbg(4'h2);
    drive(4'h2, 4'h1, 4'h2, 1'b1, 64'h77, 64'h0, 1'b1);
    expect_v("cmov_c_dstE", 64'h2); chk(64'(dstE));
    commit();
    expect_v("cmov_c_r2", 64'h77); read_dbg(4'h2);

    // Read-during-write: old value until the edge, new value after
    drive(4'h3, 4'hF, 4'h5, 1'b0, 64'h10, 64'h0, 1'b1);
    commit();
    drive(4'h6, 4'h5, 4'h5, 1'b0, 64'h20, 64'h0, 1'b1);
    expect_v("rdw_valA_old", 64'h10); chk(valA);
    expect_v("rdw_valB_old", 64'h10); chk(valB);
    expect_v("rdw_dstE", 64'h5); chk(64'(dstE));
    @(posedge clk);
    #1;
    expect_v("rdw_valA_new", 64'h20); chk(valA);
    expect_v("rdw_valB_new", 64'h20); chk(valB);
    @(negedge clk);
    wb_en = 1'b0;

    // call / ret / invalid decode
    drive(4'h8, 4'h1, 4'h2, 1'b0, 64'h0, 64'h0, 1'b0);
    expect_v("call_srcA", 64'hF); chk(64'(srcA));
    expect_v("call_srcB", 64'h4); chk(64'(srcB));
    expect_v("call_dstE", 64'h4); chk(64'(dstE));
    drive(4'h9, 4'h1, 4'h2, 1'b0, 64'h0, 64'h0, 1'b0);
    expect_v("ret_srcA", 64'h4); chk(64'(srcA));
    expect_v("ret_dstM", 64'hF); chk(64'(dstM));
    drive(4'hC, 4'h1, 4'h2, 1'b1, 64'h0, 64'h0, 1'b0);
    expect_v("inv_ids", 16'hFFFF); chk(64'({srcA, srcB, dstE, dstM}));

    // wb_en = 0 on mrmovq, preload R6 = 0x66
    drive(4'h3, 4'hF, 4'h6, 1'b0, 64'h66, 64'h0, 1'b1);
    commit();
    drive(4'h5, 4'h6, 4'hF, 1'b0, 64'h0, 64'h99, 1'b0);
    expect_v("mrmovq_dstM", 64'h6); chk(64'(dstM));
    expect_v("mrmovq_valB", 64'h0); chk(valB);
    commit();
    expect_v("wb_en0_r6", 64'h66); read_dbg(4'h6);

    // Async reset mid-cycle with a write pending
    drive(4'h3, 4'hF, 4'h7, 1'b0, 64'hDEAD, 64'h0, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    for (int i = 2; i < 7; i++) begin
      expect_v($sformatf("async_rst_r%0d", i), 64'h0);
      read_dbg(4'(i));
    end
    @(posedge clk);
    #1;
    expect_v("rst_blocks_write_r7", 64'h0); read_dbg(4'h7);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'h3, 4'hF, 4'h7, 1'b0, 64'hBEEF, 64'h0, 1'b1);
    commit();
    expect_v("post_rst_write_r7", 64'hBEEF); read_dbg(4'h7);

    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
